// File: rtl/matmul_pkg.sv
// Shared matmul constants: matrix/element sizing, header format and the result
// transmit FSM state encoding.
package matmul_pkg;

  localparam int unsigned MAX_N          = 8;
  localparam int unsigned ELEM_W         = 16;
  localparam int unsigned BYTES_PER_ELEM = (ELEM_W + 7) / 8;
  localparam int unsigned ADDR_W         = $clog2(MAX_N * MAX_N);
  localparam int unsigned N_W            = 4;
  localparam int unsigned HDR_PAD_W      = 8 - N_W;

  // Header byte is {HDR_PAD, N}
  localparam logic [HDR_PAD_W-1:0] HDR_PAD = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_RD_REQ,
    S_RD_WAIT,
    S_BYTE,
    S_ACK,
    S_DRAIN,
    S_FIN
  } tx_state_e;

endpackage

// File: rtl/elem_byte_shifter.sv
// Holds one result element zero-extended to whole bytes and presents it MSB
// byte first; advance shifts the next byte up and last_c flags the final byte.
module elem_byte_shifter
  import matmul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ELEM_W-1:0] data,
  input  logic              advance,
  output logic [7:0]        top_byte,
  output logic              last_c
);

  localparam int unsigned SR_W   = 8 * BYTES_PER_ELEM;
  localparam int unsigned BIDX_W = (BYTES_PER_ELEM > 1) ? $clog2(BYTES_PER_ELEM) : 1;

  logic [SR_W-1:0]   sr;
  logic [BIDX_W-1:0] byte_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr       <= '0;
      byte_idx <= '0;
    end else if (load) begin
      sr       <= SR_W'(data);
      byte_idx <= '0;
    end else if (advance) begin
      sr       <= sr << 8;
      byte_idx <= byte_idx + BIDX_W'(1);
    end
  end

  assign top_byte = sr[SR_W-1 -: 8];
  assign last_c   = (byte_idx == BIDX_W'(BYTES_PER_ELEM - 1));

endmodule

// File: rtl/result_tx_sequencer.sv
// Streams the product matrix to the host UART: header byte N, then N*N elements
// row-major, each MSB-first, read from the result buffer via a 1-cycle read port.
module result_tx_sequencer
  import matmul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_W-1:0]    matrix_size,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [ELEM_W-1:0] rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  tx_state_e       state;
  logic [N_W-1:0]  n_lat;
  logic [CNT_W-1:0] elem_idx;
  logic            hdr_flag;

  logic [N_W-1:0]   n_clamp_c;
  logic [CNT_W-1:0] total_c;
  logic             more_elems_c;
  logic             shift_load_c;
  logic             shift_adv_c;
  logic [7:0]       top_byte;
  logic             last_byte_c;

  assign n_clamp_c    = (matrix_size > N_W'(MAX_N)) ? N_W'(MAX_N) : matrix_size;
  // Element count is one bit wider than the address so N=MAX_N does not wrap
  assign total_c      = CNT_W'(n_lat) * CNT_W'(n_lat);
  assign more_elems_c = (elem_idx < (total_c - CNT_W'(1)));
  assign shift_load_c = (state == S_RD_WAIT);
  assign shift_adv_c  = (state == S_DRAIN) && !tx_busy && !hdr_flag && !last_byte_c;

  elem_byte_shifter u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (shift_load_c),
    .data     (rd_data),
    .advance  (shift_adv_c),
    .top_byte (top_byte),
    .last_c   (last_byte_c)
  );

  // rd_en is raised on entry to RD_REQ so data is valid throughout RD_WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      n_lat    <= '0;
      elem_idx <= '0;
      hdr_flag <= 1'b0;
      rd_addr  <= '0;
      rd_en    <= 1'b0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      rd_en    <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            n_lat    <= n_clamp_c;
            busy     <= 1'b1;
            elem_idx <= '0;
            hdr_flag <= 1'b0;
            state    <= S_HDR;
          end
        end
        S_HDR: begin
          tx_data <= {HDR_PAD, n_lat};
          if (!tx_busy) begin
            tx_start <= 1'b1;
            hdr_flag <= 1'b1;
            state    <= S_ACK;
          end
        end
        S_RD_REQ:  state <= S_RD_WAIT;
        S_RD_WAIT: state <= S_BYTE;
        S_BYTE: begin
          tx_data <= top_byte;
          if (!tx_busy) begin
            tx_start <= 1'b1;
            state    <= S_ACK;
          end
        end
        S_ACK: begin
          if (tx_busy) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!tx_busy) begin
            if (hdr_flag) begin
              hdr_flag <= 1'b0;
              if (n_lat == '0) begin
                state <= S_FIN;
              end else begin
                rd_en   <= 1'b1;
                rd_addr <= '0;
                state   <= S_RD_REQ;
              end
            end else if (!last_byte_c) begin
              state <= S_BYTE;
            end else if (more_elems_c) begin
              elem_idx <= elem_idx + CNT_W'(1);
              rd_en    <= 1'b1;
              rd_addr  <= ADDR_W'(elem_idx + CNT_W'(1));
              state    <= S_RD_REQ;
            end else begin
              state <= S_FIN;
            end
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_tx_sequencer.sv
// Directed bench for result_tx_sequencer with a UART TX model and result RAM.
module tb_result_tx_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  matrix_size;
  logic [5:0]  rd_addr;
  logic        rd_en;
  logic [15:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] ram [64];
  logic [7:0]  bytes [$];
  int ts_cnt = 0, done_cnt = 0, rd_cnt = 0, proto_err = 0, last_addr = -1;

  logic uart_busy = 1'b0;
  int   uart_cnt = 0;
  logic hold_busy = 1'b0;

  always #5 clk = ~clk;

  result_tx_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .matrix_size (matrix_size),
    .rd_addr     (rd_addr),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .busy        (busy),
    .done        (done)
  );

  assign tx_busy = uart_busy | hold_busy;

  always @(posedge clk) begin
    if (rd_en) rd_data <= ram[rd_addr];
  end

  // UART: busy rises the cycle after tx_start and stays high 10 cycles
  always @(posedge clk) begin
    if (tx_start && !tx_busy) begin
      uart_busy <= 1'b1;
      uart_cnt  <= 10;
    end else if (uart_busy) begin
      uart_cnt <= uart_cnt - 1;
      if (uart_cnt == 1) uart_busy <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (tx_start) begin
      ts_cnt++;
      if (tx_busy) proto_err++;
      else bytes.push_back(tx_data);
    end
    if (done) done_cnt++;
    if (rd_en) begin
      rd_cnt++;
      last_addr = int'(rd_addr);
    end
  end

  task automatic pulse_start(input logic [3:0] n);
    @(negedge clk);
    matrix_size = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int k;
    k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt == d0) begin
      miscompares++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
    repeat (15) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; matrix_size = 4'd0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({rd_addr, rd_en, tx_data, tx_start, busy, done} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", {rd_addr, rd_en, tx_data, tx_start, busy, done});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [9];
    logic [8:0] got;
    int b0, d0;
    exp_b = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    ram[0] = 16'h0102; ram[1] = 16'h0304; ram[2] = 16'h0506; ram[3] = 16'h0708;
    b0 = bytes.size(); d0 = done_cnt;
    pulse_start(4'd2);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL basic_busy_rise: got %b want 1", busy);
    end
    @(negedge clk);
    vectors++;
    if ({tx_start, tx_data} !== {1'b1, 8'h02}) begin
      miscompares++; $display("FAIL basic_hdr_latency: got start=%b data=%h want 1/02", tx_start, tx_data);
    end
    wait_done(d0, 400);
    vectors++;
    if (bytes.size() - b0 !== 9) begin
      miscompares++; $display("FAIL basic_count: got %0d want 9", bytes.size() - b0);
    end
    for (int i = 0; i < 9; i++) begin
      got = (b0 + i < bytes.size()) ? {1'b0, bytes[b0 + i]} : 9'h1FF;
      vectors++;
      if (got !== {1'b0, exp_b[i]}) begin
        miscompares++; $display("FAIL basic_byte%0d: got %h want %h", i, got, exp_b[i]);
      end
    end
    vectors++;
    if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL basic_done: got %0d pulses busy=%b want 1/0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_zero();
    int b0, d0, r0;
    b0 = bytes.size(); d0 = done_cnt; r0 = rd_cnt;
    pulse_start(4'd0);
    wait_done(d0, 100);
    vectors++;
    if (bytes.size() - b0 !== 1 || (bytes.size() > b0 && bytes[b0] !== 8'h00)) begin
      miscompares++; $display("FAIL zero_stream: got %0d bytes want single 00", bytes.size() - b0);
    end
    vectors++;
    if (rd_cnt - r0 !== 0 || done_cnt - d0 !== 1) begin
      miscompares++; $display("FAIL zero_reads_done: got rd=%0d done=%0d want 0/1", rd_cnt - r0, done_cnt - d0);
    end
  endtask

  task automatic test_clamp();
    int b0, d0, r0, bad;
    for (int i = 0; i < 64; i++) ram[i] = 16'(16'h1000 + i * 16'h0103);
    b0 = bytes.size(); d0 = done_cnt; r0 = rd_cnt;
    pulse_start(4'd12);
    wait_done(d0, 4000);
    vectors++;
    if (bytes.size() - b0 !== 129) begin
      miscompares++; $display("FAIL clamp_count: got %0d want 129", bytes.size() - b0);
    end
    vectors++;
    if (bytes.size() > b0 && bytes[b0] !== 8'h08) begin
      miscompares++; $display("FAIL clamp_header: got %h want 08", bytes[b0]);
    end
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (b0 + 2 * i + 2 < bytes.size()) begin
        if (bytes[b0 + 2 * i + 1] !== ram[i][15:8] || bytes[b0 + 2 * i + 2] !== ram[i][7:0]) bad++;
      end
    end
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL clamp_payload: got %0d wrong elements want 0", bad);
    end
    vectors++;
    if (rd_cnt - r0 !== 64 || last_addr !== 63) begin
      miscompares++; $display("FAIL clamp_reads: got %0d reads last=%0d want 64/63", rd_cnt - r0, last_addr);
    end
  endtask

  task automatic test_busy_hold();
    int b0, d0, t0;
    ram[0] = 16'hA55A;
    b0 = bytes.size(); d0 = done_cnt; t0 = ts_cnt;
    hold_busy = 1'b1;
    pulse_start(4'd1);
    repeat (20) @(negedge clk);
    vectors++;
    if (ts_cnt - t0 !== 0) begin
      miscompares++; $display("FAIL hold_withheld: got %0d tx_start want 0", ts_cnt - t0);
    end
    hold_busy = 1'b0;
    wait_done(d0, 200);
    vectors++;
    if (bytes.size() - b0 !== 3 ||
        (bytes.size() - b0 == 3 && {bytes[b0], bytes[b0 + 1], bytes[b0 + 2]} !== 24'h01A55A)) begin
      miscompares++; $display("FAIL hold_stream: got %0d bytes want 01 A5 5A", bytes.size() - b0);
    end
  endtask

  task automatic test_reset_mid();
    int b0, d0, t0, k;
    ram[0] = 16'h0102; ram[1] = 16'h0304; ram[2] = 16'h0506; ram[3] = 16'h0708;
    b0 = bytes.size();
    pulse_start(4'd2);
    k = 0;
    while (bytes.size() < b0 + 3 && k < 300) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (bytes.size() < b0 + 3) begin
      miscompares++; $display("FAIL rmid_third_byte: got %0d bytes want 3", bytes.size() - b0);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({rd_addr, rd_en, tx_data, tx_start, busy, done} !== 19'd0) begin
      miscompares++; $display("FAIL rmid_outputs: got %h want 0", {rd_addr, rd_en, tx_data, tx_start, busy, done});
    end
    rst = 1'b0;
    t0 = ts_cnt; d0 = done_cnt;
    repeat (100) @(negedge clk);
    vectors++;
    if (ts_cnt - t0 !== 0 || done_cnt - d0 !== 0) begin
      miscompares++; $display("FAIL rmid_quiet: got start=%0d done=%0d want 0/0", ts_cnt - t0, done_cnt - d0);
    end
    b0 = bytes.size();
    pulse_start(4'd0);
    wait_done(d0, 100);
    vectors++;
    if (bytes.size() - b0 !== 1 || done_cnt - d0 !== 1) begin
      miscompares++; $display("FAIL rmid_restart: got %0d bytes %0d done want 1/1", bytes.size() - b0, done_cnt - d0);
    end
  endtask

  task automatic test_restart_ignored();
    logic [7:0] exp_b [9];
    int b0, d0, r0, bad;
    exp_b = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    b0 = bytes.size(); d0 = done_cnt; r0 = rd_cnt;
    pulse_start(4'd2);
    repeat (30) @(negedge clk);
    pulse_start(4'd5);
    wait_done(d0, 400);
    bad = 0;
    for (int i = 0; i < 9; i++)
      if (b0 + i >= bytes.size() || bytes[b0 + i] !== exp_b[i]) bad++;
    vectors++;
    if (bad != 0 || bytes.size() - b0 !== 9) begin
      miscompares++; $display("FAIL restart_stream: got %0d bytes %0d wrong want 9/0", bytes.size() - b0, bad);
    end
    vectors++;
    if (rd_cnt - r0 !== 4 || done_cnt - d0 !== 1) begin
      miscompares++; $display("FAIL restart_counts: got rd=%0d done=%0d want 4/1", rd_cnt - r0, done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_clamp();
    test_busy_hold();
    test_reset_mid();
    test_restart_ignored();
    vectors++;
    if (proto_err !== 0) begin
      miscompares++; $display("FAIL protocol: got %0d tx_start while busy want 0", proto_err);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
